// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-redirect trap).
package fetch_unit_pkg;

  localparam int PC_W        = 8;
  localparam int INSTR_W     = 32;
  localparam int FETCH_DEPTH = 2;
  localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);
  localparam int PTR_W       = $clog2(FETCH_DEPTH);

  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FETCH_DEPTH);
  localparam logic [CNT_W-1:0] FIFO_EMPTY = {CNT_W{1'b0}};

  typedef enum logic [0:0] {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam fetch_entry_t ENTRY_ZERO = '{pc: 8'd0, instr: 32'd0};

  function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: memory address/data, decode handshake, redirect and status.
// Used by fetch_unit (master) and its environment (slave).
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [PC_W-1:0]    inst_address;
  logic [INSTR_W-1:0] inst_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               halted;
  logic               fetch_err;

  modport master (
    output inst_address, out_valid, out_instr, out_pc, halted, fetch_err,
    input  inst_data, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  inst_address, out_valid, out_instr, out_pc, halted, fetch_err,
    output inst_data, out_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO of {pc, instr} with push/pop/flush.
// Flush wins over push and pop; the head reads as zero while empty.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     wr_data_i,
  output fetch_entry_t     head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_next_o
);

  fetch_entry_t     mem_q [FETCH_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointer and occupancy next-state
  always_comb begin
    do_push_s = push_i && (count_q != FIFO_FULL);
    do_pop_s  = pop_i && (count_q != FIFO_EMPTY);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = FIFO_EMPTY;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= FIFO_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        mem_q[i] <= ENTRY_ZERO;
      end
    end else if (do_push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Head presentation
  always_comb begin
    valid_o = (count_q != FIFO_EMPTY);
    if (valid_o) begin
      head_o = mem_q[rd_ptr_q];
    end else begin
      head_o = ENTRY_ZERO;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, RUN/HALT control, redirect and halt status.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects into a sticky fetch_err.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'd0,
  parameter logic [PC_W-1:0] PROG_END = 8'd80,
  parameter logic [PC_W-1:0] PC_STEP  = 8'd4
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             halted_q, halted_d;
  logic             push_s;
  logic             pop_s;
  logic             flush_s;
  fetch_entry_t     wr_entry_s;
  fetch_entry_t     head_s;
  logic             head_valid_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] count_next_s;

  // Fetch/pop decisions use the registered count only
  always_comb begin
    flush_s    = bus.redirect_valid;
    pop_s      = head_valid_s && bus.out_ready;
    push_s     = (state_q == FS_RUN) && (pc_q < PROG_END) &&
                 (count_s < FIFO_FULL) && !bus.redirect_valid;
    wr_entry_s = '{pc: pc_q, instr: bus.inst_data};
  end

  fetch_fifo u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push_s),
    .pop_i        (pop_s),
    .flush_i      (flush_s),
    .wr_data_i    (wr_entry_s),
    .head_o       (head_s),
    .valid_o      (head_valid_s),
    .count_o      (count_s),
    .count_next_o (count_next_s)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_err_q, fetch_err_d;
  logic bad_align_s;
`endif

  // PC, state and halt next-state; redirect overrides everything else
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
`ifdef FETCH_ALIGN_CHECK_EN
    bad_align_s = bus.redirect_valid && pc_misaligned(bus.redirect_pc);
    fetch_err_d = fetch_err_q | bad_align_s;
`endif
    if (bus.redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (bad_align_s) begin
        pc_d    = {bus.redirect_pc[PC_W-1:2], 2'b00};
        state_d = FS_HALT;
      end else begin
        pc_d    = bus.redirect_pc;
        state_d = FS_RUN;
      end
`else
      pc_d    = bus.redirect_pc;
      state_d = FS_RUN;
`endif
    end else begin
      if (push_s) begin
        pc_d = pc_q + PC_STEP;
      end else begin
        pc_d = pc_q;
      end
      case (state_q)
        FS_RUN:  state_d = (pc_q >= PROG_END) ? FS_HALT : FS_RUN;
        FS_HALT: state_d = FS_HALT;
        default: state_d = FS_HALT;
      endcase
    end
    // Built from next-state values so halted agrees with state/count after each edge
    halted_d = (state_d == FS_HALT) && (count_next_s == FIFO_EMPTY);
  end

  // PC, state and halt registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      state_q  <= FS_RUN;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky misaligned-redirect flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= fetch_err_d;
    end
  end

  assign bus.fetch_err = fetch_err_q;
`else
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.inst_address = pc_q;
  assign bus.out_valid    = head_valid_s;
  assign bus.out_instr    = head_s.instr;
  assign bus.out_pc       = head_s.pc;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequential fetch, backpressure,
// redirect flush, halt/restart, async reset and misaligned redirect.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (8'd0),
    .PROG_END (8'd80),
    .PC_STEP  (8'd4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {8'hC0, a, a ^ 8'h5A, ~a};
  endfunction

  assign bus.inst_data = mem_word(bus.inst_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [7:0] pc);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_pc"}, {24'd0, bus.out_pc}, {24'd0, pc});
    chk({tag, "_instr"}, bus.out_instr, mem_word(pc));
  endtask

  // Expects out_ready=1 and the first capture edge still ahead
  task automatic run_program(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_head($sformatf("%s_seq%0d", tag, i), 8'(4 * i));
      if (i == 10) chk({tag, "_not_halted"}, {31'd0, bus.halted}, 32'd0);
    end
    @(negedge clk);
    chk({tag, "_end_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_end_halted"}, {31'd0, bus.halted}, 32'd1);
    chk({tag, "_end_addr"}, {24'd0, bus.inst_address}, 32'd80);
    @(negedge clk);
    chk({tag, "_hold_addr"}, {24'd0, bus.inst_address}, 32'd80);
    chk({tag, "_hold_halted"}, {31'd0, bus.halted}, 32'd1);
    chk({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_pc", {24'd0, bus.out_pc}, 32'd0);
    chk("rst_addr", {24'd0, bus.inst_address}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_err", {31'd0, bus.fetch_err}, 32'd0);

    // Full program with decode always ready
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    run_program("run1");

    // Redirect out of HALT back to 0 repeats the program
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'd0;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("restart_halted", {31'd0, bus.halted}, 32'd0);
    chk("restart_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("restart_addr", {24'd0, bus.inst_address}, 32'd0);
    run_program("run2");

    // Backpressure from reset: FIFO fills with 0 and 4
    @(negedge clk);
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("bp_rst_addr", {24'd0, bus.inst_address}, 32'd0);
    chk("bp_rst_halted", {31'd0, bus.halted}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_head("bp_first", 8'd0);
    @(negedge clk);
    check_head("bp_full_a", 8'd0);
    chk("bp_full_a_addr", {24'd0, bus.inst_address}, 32'd8);
    @(negedge clk);
    check_head("bp_full_b", 8'd0);
    chk("bp_full_b_addr", {24'd0, bus.inst_address}, 32'd8);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_head("bp_drain4", 8'd4);
    @(negedge clk);
    check_head("bp_drain8", 8'd8);
    chk("bp_drain8_addr", {24'd0, bus.inst_address}, 32'd12);

    // Fill with 8,12 then redirect to 40
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_head("rd_hold8", 8'd8);
    chk("rd_hold_addr", {24'd0, bus.inst_address}, 32'd16);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'd40;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("rd_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rd_flush_addr", {24'd0, bus.inst_address}, 32'd40);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_head("rd_tgt40", 8'd40);
    @(negedge clk);
    check_head("rd_tgt44", 8'd44);

    // Async reset while full, between clock edges
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_head("ar_full", 8'd44);
    chk("ar_full_addr", {24'd0, bus.inst_address}, 32'd52);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ar_addr", {24'd0, bus.inst_address}, 32'd0);
    chk("ar_pc", {24'd0, bus.out_pc}, 32'd0);
    chk("ar_instr", bus.out_instr, 32'd0);

    // Redirect to an unaligned target
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_head("ma_first", 8'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'd42;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("ma_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("ma_addr", {24'd0, bus.inst_address}, 32'd40);
    chk("ma_err", {31'd0, bus.fetch_err}, 32'd1);
    chk("ma_halted", {31'd0, bus.halted}, 32'd1);
    @(negedge clk);
    chk("ma_nofetch_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ma_nofetch_addr", {24'd0, bus.inst_address}, 32'd40);
`else
    chk("ma_addr", {24'd0, bus.inst_address}, 32'd42);
    chk("ma_err", {31'd0, bus.fetch_err}, 32'd0);
    chk("ma_halted", {31'd0, bus.halted}, 32'd0);
    @(negedge clk);
    check_head("ma_tgt42", 8'd42);
`endif
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'd16;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("al_addr", {24'd0, bus.inst_address}, 32'd16);
    chk("al_halted", {31'd0, bus.halted}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("al_err_sticky", {31'd0, bus.fetch_err}, 32'd1);
`else
    chk("al_err", {31'd0, bus.fetch_err}, 32'd0);
`endif
    @(negedge clk);
    check_head("al_tgt16", 8'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
